// File: rtl/regfile_seq.sv
// Command sequencer driving a 16x4 register file with a registered read port.
// Runs one command at a time: read, ALU, write back, then a done pulse.
module regfile_seq #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rr1,
  output logic [AW-1:0] rr2,
  output logic [AW-1:0] wr,
  output logic [DW-1:0] wdata,
  output logic          wenable,
  input  logic [DW-1:0] outreg1,
  input  logic [DW-1:0] outreg2,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero,
  output logic          done
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic          accept;
  logic          is_ldi;

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_c;

  assign accept = cmd_valid && cmd_ready;
  assign is_ldi = (cmd_op == OP_LDI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = is_ldi ? S_WRITE : S_READ;
        end
      end
      S_READ:  state_n = S_CAPT;
      S_CAPT:  state_n = (op_q == OP_RD) ? S_DONE : S_WRITE;
      S_WRITE: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = {1'b0, outreg1} + {1'b0, outreg2};
    diff    = {1'b0, outreg1} - {1'b0, outreg2};
    unique case (1'b1)
      (op_q == OP_ADD): begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      (op_q == OP_SUB): begin
        alu_res = diff[DW-1:0];
        alu_c   = diff[DW];
      end
      (op_q == OP_AND): alu_res = outreg1 & outreg2;
      (op_q == OP_OR):  alu_res = outreg1 | outreg2;
      (op_q == OP_XOR): alu_res = outreg1 ^ outreg2;
      (op_q == OP_MOV),
      (op_q == OP_RD):  alu_res = outreg1;
      default: alu_res = '0;
    endcase
  end

  // Handshake/strobe outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      wenable   <= 1'b0;
      done      <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rr1       <= '0;
      rr2       <= '0;
      wr        <= '0;
      wdata     <= '0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      cmd_ready <= (state_n == S_IDLE);
      wenable   <= (state_n == S_WRITE);
      done      <= (state_n == S_DONE);
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        if (is_ldi) begin
          wr     <= cmd_rd;
          wdata  <= cmd_imm;
          result <= cmd_imm;
          carry  <= 1'b0;
          zero   <= (cmd_imm == '0);
        end else begin
          rr1 <= cmd_rs1;
          rr2 <= cmd_rs2;
        end
      end
      if (state == S_CAPT) begin
        result <= alu_res;
        carry  <= alu_c;
        zero   <= (alu_res == '0);
        if (op_q != OP_RD) begin
          wr    <= rd_q;
          wdata <= alu_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: register file model, vector table and scoreboard.
// Done and write events are popped from queues filled when commands are driven.
module tb_regfile_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_rs1;
  logic [3:0] cmd_rs2;
  logic [3:0] cmd_rd;
  logic [3:0] cmd_imm;
  logic [3:0] rr1;
  logic [3:0] rr2;
  logic [3:0] wr;
  logic [3:0] wdata;
  logic       wenable;
  logic [3:0] outreg1;
  logic [3:0] outreg2;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       done;

  regfile_seq #(.DW(4), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs1(cmd_rs1),
    .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm),
    .rr1(rr1), .rr2(rr2), .wr(wr),
    .wdata(wdata), .wenable(wenable),
    .outreg1(outreg1), .outreg2(outreg2),
    .result(result), .carry(carry),
    .zero(zero), .done(done)
  );

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDI = 3'd5;
  localparam logic [2:0] MOV = 3'd6;
  localparam logic [2:0] RD  = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] imm;
    logic [3:0] res;
    logic       c;
    logic       z;
    int         lat;
    bit         wen;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       z;
    int         lat;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_total = 0;

  exp_t       exp_q[$];
  logic [7:0] wq[$];
  int         acc_q[$];
  vec_t       vecs[$];

  // Register file: registered read, bogus data the cycle after a write.
  logic [3:0] mem [16];

  always @(posedge clk) begin
    if (wenable) mem[wr] <= wdata;
    outreg1 <= wenable ? ~mem[rr1] : mem[rr1];
    outreg2 <= wenable ? ~mem[rr2] : mem[rr2];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc + 1);
        acc_total++;
      end
      if (wenable) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected wr=%0d wdata=%0d", wr, wdata);
        end else begin
          logic [7:0] w;
          w = wq.pop_front();
          if ({wr, wdata} !== w) begin
            failures++;
            $display("FAIL write got wr=%0d wdata=%0d want wr=%0d wdata=%0d",
                     wr, wdata, w[7:4], w[3:0]);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected result=%0d", result);
        end else begin
          exp_t e;
          int a;
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          if (result !== e.res || carry !== e.c || zero !== e.z ||
              (cyc - a) != e.lat) begin
            failures++;
            $display("FAIL done got res=%0d c=%0b z=%0b lat=%0d want res=%0d c=%0b z=%0b lat=%0d",
                     result, carry, zero, cyc - a, e.res, e.c, e.z, e.lat);
          end
        end
      end
    end
  end

  function automatic vec_t mk(logic [2:0] op, logic [3:0] rs1,
                              logic [3:0] rs2, logic [3:0] rd,
                              logic [3:0] imm, logic [3:0] res,
                              logic c, logic z);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    v.res = res; v.c = c; v.z = z;
    v.lat = (op == LDI) ? 1 : (op == RD) ? 2 : 3;
    v.wen = (op != RD);
    return v;
  endfunction

  task automatic expect_cmd(vec_t v);
    exp_t e;
    e.res = v.res; e.c = v.c; e.z = v.z; e.lat = v.lat;
    exp_q.push_back(e);
    if (v.wen) wq.push_back({v.rd, v.res});
  endtask

  task automatic set_cmd(vec_t v);
    cmd_op = v.op; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2;
    cmd_rd = v.rd; cmd_imm = v.imm;
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL %s ready_timeout got=0 want=1", name);
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s done_timeout pending=%0d want=0", name, exp_q.size());
      exp_q.delete(); wq.delete(); acc_q.delete();
    end
  endtask

  task automatic run_cmd(vec_t v, string name);
    expect_cmd(v);
    @(posedge clk); #1;
    set_cmd(v);
    cmd_valid = 1'b1;
    wait_ready(name);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    int busy;
    int acc0;
    vec_t a;
    vec_t b;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;

    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || wenable !== 1'b0 || done !== 1'b0 ||
        result !== 4'd0 || carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0b we=%0b dn=%0b res=%0d c=%0b z=%0b want 1 0 0 0 0 0",
               cmd_ready, wenable, done, result, carry, zero);
    end
    @(posedge clk); #2;
    rst = 1'b0;

    vecs.push_back(mk(LDI, 0, 0, 3, 5, 5, 0, 0));
    vecs.push_back(mk(LDI, 0, 0, 4, 9, 9, 0, 0));
    vecs.push_back(mk(ADD, 3, 4, 5, 0, 14, 0, 0));
    vecs.push_back(mk(RD,  5, 0, 0, 0, 14, 0, 0));
    vecs.push_back(mk(LDI, 0, 0, 1, 9, 9, 0, 0));
    vecs.push_back(mk(ADD, 1, 1, 1, 0, 2, 1, 0));
    vecs.push_back(mk(RD,  1, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(LDI, 0, 0, 2, 3, 3, 0, 0));
    vecs.push_back(mk(LDI, 0, 0, 6, 5, 5, 0, 0));
    vecs.push_back(mk(SUB, 2, 6, 7, 0, 14, 1, 0));
    vecs.push_back(mk(RD,  7, 0, 0, 0, 14, 0, 0));
    vecs.push_back(mk(XOR, 2, 2, 8, 0, 0, 0, 1));
    vecs.push_back(mk(AND, 3, 4, 12, 0, 1, 0, 0));
    vecs.push_back(mk(OR,  3, 4, 13, 0, 13, 0, 0));
    vecs.push_back(mk(MOV, 4, 0, 14, 0, 9, 0, 0));
    vecs.push_back(mk(LDI, 0, 0, 15, 0, 0, 0, 1));
    vecs.push_back(mk(SUB, 4, 3, 0, 0, 4, 0, 0));
    vecs.push_back(mk(RD,  14, 0, 0, 0, 9, 0, 0));

    foreach (vecs[i]) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // cmd_valid held high across two back-to-back commands
    a = mk(LDI, 0, 0, 10, 6, 6, 0, 0);
    b = mk(ADD, 10, 10, 11, 0, 12, 0, 0);
    expect_cmd(a);
    expect_cmd(b);
    acc0 = acc_total;
    @(posedge clk); #1;
    set_cmd(a);
    cmd_valid = 1'b1;
    wait_ready("held_a");
    @(posedge clk); #1;
    set_cmd(b);
    busy = 0;
    @(negedge clk);
    while (!cmd_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle("held_b");
    checks++;
    if (busy != 2) begin
      failures++;
      $display("FAIL held_busy got=%0d want=2", busy);
    end
    checks++;
    if (acc_total - acc0 != 2) begin
      failures++;
      $display("FAIL held_accepts got=%0d want=2", acc_total - acc0);
    end
    run_cmd(mk(RD, 11, 0, 0, 0, 12, 0, 0), "held_rd");

    // reset during the write cycle of ADD r9 = r9 + r9
    run_cmd(mk(LDI, 0, 0, 9, 7, 7, 0, 0), "ldi_r9");
    a = mk(ADD, 9, 9, 9, 0, 14, 0, 0);
    expect_cmd(a);
    @(posedge clk); #1;
    set_cmd(a);
    cmd_valid = 1'b1;
    wait_ready("abort");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    busy = 0;
    @(negedge clk);
    while (!wenable && busy < 10) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (!wenable) begin
      failures++;
      $display("FAIL abort_write_seen got=0 want=1");
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (wenable !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 ||
        result !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got we=%0b dn=%0b rdy=%0b res=%0d want 0 0 1 0",
               wenable, done, cmd_ready, result);
    end
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_cmd(mk(RD, 9, 0, 0, 0, 7, 0, 0), "rd_r9_after_abort");

    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got writes=%0d dones=%0d want 0 0",
               wq.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
